// File: rtl/mcp49x2_dac.sv
// mcp49x2_dac: SPI master for the MCP4902/4912/4922 dual DAC.
// One-deep input buffer with ready/valid handshake, programmable SCLK divider,
// minimum CS-high gap and optional LDAC pulse after channel-B frames.
module mcp49x2_dac #(
    parameter int DATA_BITS  = 12,
    parameter int CLK_DIV    = 1,
    parameter int CS_GAP     = 1,
    parameter int GAIN       = 1,
    parameter int BUFFERED   = 1,
    parameter int LDAC_MODE  = 0,
    parameter int LDAC_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 cs_pin,
    output logic                 clk_pin,
    output logic                 data_pin,
    output logic                 ldac_pin,
    input  logic [DATA_BITS-1:0] value,
    input  logic                 axis,
    input  logic                 shdn_n,
    input  logic                 strobe,
    output logic                 ready,
    output logic                 busy,
    output logic                 frame_done
);

    // state  | meaning
    // IDLE   | CS high, waiting for a buffered word
    // LOW    | SCLK low, SDI presents current MSB
    // HIGH   | SCLK high, DAC samples SDI
    // TAIL   | SCLK low, CS still low after the 16th bit
    // GAP    | CS high for the minimum inter-frame gap
    // LDAC   | LDAC pulsed low after a channel-B frame
    typedef enum logic [2:0] {
        S_IDLE, S_LOW, S_HIGH, S_TAIL, S_GAP, S_LDAC
    } state_t;

    localparam int              CW       = 16;
    localparam int              SHIFT    = 12 - DATA_BITS;
    localparam logic            LDAC_EN  = (LDAC_MODE != 0);
    localparam logic            BUF_BIT  = (BUFFERED != 0);
    localparam logic            GA_BIT   = (GAIN != 0);
    localparam logic [CW-1:0]   DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   GAP_LD   = CW'(CS_GAP - 1);
    localparam logic [CW-1:0]   LDAC_LD  = CW'(LDAC_WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    state_t          state_q;
    logic [15:0]     buf_q;
    logic            buf_valid_q;
    logic [15:0]     sr_q;
    logic [4:0]      bits_q;
    logic [CW-1:0]   cnt_q;
    logic            axis_q;
    logic            cs_q;
    logic            sclk_q;
    logic            sdi_q;
    logic            ldac_q;
    logic            done_q;

    logic [11:0]     value12_d;
    logic [15:0]     word_d;
    logic            accept;
    logic            drain;
    logic            cnt_zero;

    assign value12_d = 12'(value) << SHIFT;
    assign word_d    = {axis, BUF_BIT, GA_BIT, shdn_n, value12_d};
    assign ready     = reset && !buf_valid_q;
    assign accept    = strobe && ready;
    assign drain     = (state_q == S_IDLE) && buf_valid_q;
    assign cnt_zero  = (cnt_q == '0);
    assign busy      = (state_q != S_IDLE) || buf_valid_q;

    assign cs_pin     = cs_q;
    assign clk_pin    = sclk_q;
    assign data_pin   = sdi_q;
    assign ldac_pin   = ldac_q;
    assign frame_done = done_q;

    // One-deep input buffer: filled on handshake, emptied when the engine loads it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else if (drain) begin
            buf_valid_q <= 1'b0;
        end else if (accept) begin
            buf_valid_q <= 1'b1;
            buf_q       <= word_d;
        end
    end

    // Frame engine: serialises the 16-bit word and sequences CS, SCLK and LDAC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            ldac_q  <= LDAC_EN;
            done_q  <= 1'b0;
            sr_q    <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            axis_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (buf_valid_q) begin
                        sr_q    <= buf_q;
                        axis_q  <= buf_q[15];
                        sdi_q   <= buf_q[15];
                        bits_q  <= 5'd16;
                        cs_q    <= 1'b0;
                        cnt_q   <= DIV_LD;
                        state_q <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (cnt_zero) begin
                        sclk_q  <= 1'b1;
                        cnt_q   <= DIV_LD;
                        state_q <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (cnt_zero) begin
                        sclk_q <= 1'b0;
                        sr_q   <= {sr_q[14:0], 1'b0};
                        bits_q <= bits_q - 5'd1;
                        cnt_q  <= DIV_LD;
                        if (bits_q == 5'd1) begin
                            sdi_q   <= 1'b0;
                            state_q <= S_TAIL;
                        end else begin
                            sdi_q   <= sr_q[14];
                            state_q <= S_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_TAIL: begin
                    if (cnt_zero) begin
                        cs_q    <= 1'b1;
                        done_q  <= 1'b1;
                        cnt_q   <= GAP_LD;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_zero) begin
                        if (LDAC_EN && axis_q) begin
                            ldac_q  <= 1'b0;
                            cnt_q   <= LDAC_LD;
                            state_q <= S_LDAC;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_LDAC: begin
                    if (cnt_zero) begin
                        ldac_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
